// File: rtl/game_sprite_pkg.sv
// Shared types for the sprite controller: FSM state encoding and direction constants.
package game_sprite_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/game_sprite_axis_step.sv
// Combinational next-position / next-direction / edge logic for one axis.
// GAME_SPRITE_BOUNCE_EN selects bounce (clamp + reverse); otherwise the axis wraps.
module game_sprite_axis_step
    import game_sprite_pkg::*;
#(
    parameter int W     = 10,
    parameter int SW    = 4,
    parameter int LIMIT = 632
) (
    input  logic [W-1:0]  pos,
    input  logic          dir,
    input  logic [SW-1:0] speed,
    output logic [W-1:0]  pos_next,
    output logic          dir_next,
    output logic          edge_hit
);

    localparam logic [W:0] LIM    = (W+1)'(LIMIT);
    localparam logic [W:0] LIM_P1 = (W+1)'(LIMIT + 1);

    logic [W:0] cand;
    logic       under;
    logic       over;

    // One extra bit: the MSB flags a negative candidate since pos + speed never reaches 2^W.
    assign cand  = (dir == DIR_NEG) ? ({1'b0, pos} - (W+1)'(speed))
                                    : ({1'b0, pos} + (W+1)'(speed));
    assign under = cand[W];
    assign over  = !cand[W] && (cand > LIM);

    always_comb begin
        pos_next = cand[W-1:0];
        dir_next = dir;
        edge_hit = 1'b0;
`ifdef GAME_SPRITE_BOUNCE_EN
        if (over) begin
            pos_next = LIM[W-1:0];
            dir_next = DIR_NEG;
            edge_hit = 1'b1;
        end else if (under) begin
            pos_next = '0;
            dir_next = DIR_POS;
            edge_hit = 1'b1;
        end
`else
        if (over) begin
            pos_next = W'(cand - LIM_P1);
            edge_hit = 1'b1;
        end else if (under) begin
            pos_next = W'(cand + LIM_P1);
            edge_hit = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/game_sprite_control.sv
// Sprite motion controller: IDLE/MOVE/HOLD FSM with per-frame position update.
// Edge behaviour (bounce vs wrap) is chosen by GAME_SPRITE_BOUNCE_EN.
module game_sprite_control
    import game_sprite_pkg::*;
#(
    parameter int screen_width  = 640,
    parameter int screen_height = 480,
    parameter int w_x           = $clog2(screen_width),
    parameter int w_y           = $clog2(screen_height),
    parameter int SPRITE_WIDTH  = 8,
    parameter int SPRITE_HEIGHT = 8,
    parameter int START_X       = 0,
    parameter int START_Y       = 0,
    parameter int SPEED_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               launch,
    input  logic               stop,
    input  logic               restart,
    input  logic               dir_x_in,
    input  logic               dir_y_in,
    input  logic [SPEED_W-1:0] speed_x,
    input  logic [SPEED_W-1:0] speed_y,
    output logic [w_x-1:0]     sprite_x,
    output logic [w_y-1:0]     sprite_y,
    output logic               moving,
    output logic               edge_x,
    output logic               edge_y
);

    localparam int XMAX = screen_width - SPRITE_WIDTH;
    localparam int YMAX = screen_height - SPRITE_HEIGHT;

    state_t         state_reg;
    logic [w_x-1:0] x_reg;
    logic [w_y-1:0] y_reg;
    logic           dir_x_reg, dir_y_reg;
    logic           moving_reg, edge_x_reg, edge_y_reg;

    logic [w_x-1:0] x_next;
    logic [w_y-1:0] y_next;
    logic           dir_x_next, dir_y_next;
    logic           hit_x, hit_y;

    game_sprite_axis_step #(.W(w_x), .SW(SPEED_W), .LIMIT(XMAX)) u_step_x (
        .pos      (x_reg),
        .dir      (dir_x_reg),
        .speed    (speed_x),
        .pos_next (x_next),
        .dir_next (dir_x_next),
        .edge_hit (hit_x)
    );

    game_sprite_axis_step #(.W(w_y), .SW(SPEED_W), .LIMIT(YMAX)) u_step_y (
        .pos      (y_reg),
        .dir      (dir_y_reg),
        .speed    (speed_y),
        .pos_next (y_next),
        .dir_next (dir_y_next),
        .edge_hit (hit_y)
    );

    // Controls are prioritised restart > stop > launch; a frame update only happens
    // when none of them is active in the tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            x_reg      <= w_x'(START_X);
            y_reg      <= w_y'(START_Y);
            dir_x_reg  <= DIR_POS;
            dir_y_reg  <= DIR_POS;
            moving_reg <= 1'b0;
            edge_x_reg <= 1'b0;
            edge_y_reg <= 1'b0;
        end else begin
            edge_x_reg <= 1'b0;
            edge_y_reg <= 1'b0;
            if (restart) begin
                state_reg  <= IDLE;
                x_reg      <= w_x'(START_X);
                y_reg      <= w_y'(START_Y);
                dir_x_reg  <= DIR_POS;
                dir_y_reg  <= DIR_POS;
                moving_reg <= 1'b0;
            end else if (stop) begin
                if (state_reg == MOVE) begin
                    state_reg  <= HOLD;
                    moving_reg <= 1'b0;
                end
            end else if (launch) begin
                if (state_reg == IDLE) begin
                    state_reg  <= MOVE;
                    dir_x_reg  <= dir_x_in;
                    dir_y_reg  <= dir_y_in;
                    moving_reg <= 1'b1;
                end else if (state_reg == HOLD) begin
                    state_reg  <= MOVE;
                    moving_reg <= 1'b1;
                end
            end else if (frame_tick && state_reg == MOVE) begin
                x_reg      <= x_next;
                y_reg      <= y_next;
                dir_x_reg  <= dir_x_next;
                dir_y_reg  <= dir_y_next;
                edge_x_reg <= hit_x;
                edge_y_reg <= hit_y;
            end
        end
    end

    assign sprite_x = x_reg;
    assign sprite_y = y_reg;
    assign moving   = moving_reg;
    assign edge_x   = edge_x_reg;
    assign edge_y   = edge_y_reg;

endmodule

// File: tb/tb_game_sprite_control.sv
// Scoreboard bench for game_sprite_control: directed scenarios then random traffic,
// expected outputs from a behavioural model; honours GAME_SPRITE_BOUNCE_EN.
module tb_game_sprite_control;

    localparam int XMAX = 640 - 8;
    localparam int YMAX = 480 - 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0, launch = 1'b0, stop = 1'b0, restart = 1'b0;
    logic       dir_x_in = 1'b0, dir_y_in = 1'b0;
    logic [3:0] speed_x = '0, speed_y = '0;
    logic [9:0] sprite_x;
    logic [8:0] sprite_y;
    logic       moving, edge_x, edge_y;

    game_sprite_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .launch     (launch),
        .stop       (stop),
        .restart    (restart),
        .dir_x_in   (dir_x_in),
        .dir_y_in   (dir_y_in),
        .speed_x    (speed_x),
        .speed_y    (speed_y),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .moving     (moving),
        .edge_x     (edge_x),
        .edge_y     (edge_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit mv;
        bit ex;
        bit ey;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: 0 = idle, 1 = moving, 2 = held
    int m_state = 0;
    int m_x = 0, m_y = 0;
    bit m_dx = 0, m_dy = 0;

    function automatic void axis(inout int p, inout bit d, input int spd, input int lim,
                                 output bit e);
        int c = d ? p - spd : p + spd;
        e = 0;
`ifdef GAME_SPRITE_BOUNCE_EN
        if (c > lim) begin c = lim; d = 1; e = 1; end
        else if (c < 0) begin c = 0; d = 0; e = 1; end
`else
        if (c > lim) begin c = c - (lim + 1); e = 1; end
        else if (c < 0) begin c = c + (lim + 1); e = 1; end
`endif
        p = c;
    endfunction

    task automatic compare(input string name, input exp_t e);
        n_vec++;
        if (int'(sprite_x) != e.x || int'(sprite_y) != e.y || moving != e.mv ||
            edge_x != e.ex || edge_y != e.ey) begin
            n_err++;
            $display("FAIL %s: got x=%0d y=%0d mv=%0b ex=%0b ey=%0b, want x=%0d y=%0d mv=%0b ex=%0b ey=%0b",
                     name, sprite_x, sprite_y, moving, edge_x, edge_y, e.x, e.y, e.mv, e.ex, e.ey);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the post-edge expectation.
    task automatic step(input logic ft, input logic la, input logic st, input logic rs,
                        input logic dxi, input logic dyi, input logic [3:0] sx,
                        input logic [3:0] sy, input logic rn);
        exp_t e;
        bit ex = 0, ey = 0;
        @(negedge clk);
        frame_tick = ft; launch = la; stop = st; restart = rs;
        dir_x_in = dxi; dir_y_in = dyi; speed_x = sx; speed_y = sy; rst_n = rn;
        if (!rn) begin
            m_state = 0; m_x = 0; m_y = 0; m_dx = 0; m_dy = 0;
            #1;
            e = '{x: 0, y: 0, mv: 0, ex: 0, ey: 0};
            compare("async_reset", e);
        end else if (rs) begin
            m_state = 0; m_x = 0; m_y = 0; m_dx = 0; m_dy = 0;
        end else if (st) begin
            if (m_state == 1) m_state = 2;
        end else if (la) begin
            if (m_state == 0) begin
                m_state = 1; m_dx = dxi; m_dy = dyi;
            end else if (m_state == 2) begin
                m_state = 1;
            end
        end else if (ft && m_state == 1) begin
            axis(m_x, m_dx, int'(sx), XMAX, ex);
            axis(m_y, m_dy, int'(sy), YMAX, ey);
        end
        e = '{x: m_x, y: m_y, mv: (m_state == 1), ex: ex, ey: ey};
        q.push_back(e);
    endtask

    task automatic tick(input logic [3:0] sx, input logic [3:0] sy);
        step(1, 0, 0, 0, 0, 0, sx, sy, 1);
    endtask

    task automatic ctl(input logic la, input logic st, input logic rs,
                       input logic dxi, input logic dyi);
        step(0, la, st, rs, dxi, dyi, 4'd0, 4'd0, 1);
    endtask

    // Directed check of a hand-derived position right after the last queued edge.
    task automatic expect_xy(input string name, input int x, input int y);
        @(posedge clk);
        #2;
        n_vec++;
        if (int'(sprite_x) != x || int'(sprite_y) != y) begin
            n_err++;
            $display("FAIL %s: got x=%0d y=%0d, want x=%0d y=%0d", name, sprite_x, sprite_y, x, y);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                compare("scoreboard", e);
            end
        end
    end

    initial begin : stim
        exp_t r;
        #1;
        r = '{x: 0, y: 0, mv: 0, ex: 0, ey: 0};
        compare("reset_state", r);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Launch +/+ with speeds 3/2
        ctl(1, 0, 0, 0, 0);
        tick(3, 2); expect_xy("launch_t1", 3, 2);
        tick(3, 2); expect_xy("launch_t2", 6, 4);
        tick(3, 2); expect_xy("launch_t3", 9, 6);

        // Right edge from 630 with speed 4
        ctl(0, 0, 1, 0, 0);
        ctl(1, 0, 0, 0, 0);
        for (int i = 0; i < 42; i++) tick(15, 0);
        expect_xy("reach_630", 630, 0);
        tick(4, 0);
`ifdef GAME_SPRITE_BOUNCE_EN
        expect_xy("bounce_clamp", 632, 0);
        tick(4, 0); expect_xy("bounce_back", 628, 0);
`else
        expect_xy("wrap_right", 1, 0);
        // Leftward from 2 with speed 4
        ctl(0, 0, 1, 0, 0);
        ctl(1, 0, 0, 1, 0);
        tick(15, 0); expect_xy("wrap_left0", 618, 0);
        for (int i = 0; i < 41; i++) tick(15, 0);
        tick(1, 0); expect_xy("reach_2", 2, 0);
        tick(4, 0); expect_xy("wrap_left", 631, 0);
`endif

        // Priority: restart wins over everything; stop wins over launch
        step(1, 1, 1, 1, 0, 0, 5, 5, 1); expect_xy("prio_restart", 0, 0);
        ctl(1, 0, 0, 0, 0);
        tick(7, 3);
        step(1, 1, 1, 0, 0, 0, 5, 5, 1);
        tick(5, 5); expect_xy("prio_hold", 7, 3);

`ifndef GAME_SPRITE_BOUNCE_EN
        // Hold/resume at X = 100 moving left
        ctl(0, 0, 1, 0, 0);
        ctl(1, 0, 0, 1, 0);
        for (int i = 0; i < 35; i++) tick(15, 0);
        tick(8, 0); expect_xy("reach_100", 100, 0);
        ctl(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(9, 0);
        expect_xy("hold_freeze", 100, 0);
        ctl(1, 0, 0, 0, 0);
        tick(5, 0); expect_xy("resume", 95, 0);
`endif

        // Async reset mid-move, then ticks without launch
        ctl(0, 0, 1, 0, 0);
        ctl(1, 0, 0, 0, 0);
        tick(6, 6);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(6, 6);
        expect_xy("post_reset", 0, 0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 3) == 0, ($urandom % 10) == 0, ($urandom % 25) == 0,
                 ($urandom % 80) == 0, 1'($urandom), 1'($urandom),
                 4'($urandom), 4'($urandom), ($urandom % 300) != 0);
        end
        ctl(0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #3;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
